coin_acceptor: RTL

//  Front-end of the vending datapath: turns raw, asynchronous, bouncy slot sensors

---
 rtl/vend_pkg.sv | 18 +
 rtl/coin_debounce.sv | 61 ++++++
 rtl/coin_acceptor.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared vending datapath definitions: arbitration state, coin-kind encoding
// and the default debounce length.
package vend_pkg;

  // Arbitration FSM: either no coin is held, or one coin waits for accept_en.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Kind bit stored alongside a held coin.
  localparam logic KIND_5  = 1'b0;
  localparam logic KIND_10 = 1'b1;

  // Consecutive stable synchronized samples needed to change a debounced level.
  localparam int DB_CYCLES_DEF = 8;

endpackage

// File: rtl/coin_debounce.sv
// One coin slot: 2-flop synchronizer, debounce counter and a rising-edge
// detector. det is high for exactly one cycle when the debounced level rises.
module coin_debounce
  import vend_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int DB_W      = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic det
);

  // Counter value on which one more mismatching sample flips the level.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            db_q;
  logic            db_d;
  logic            db_prev_q;
  logic [DB_W-1:0] cnt_q;
  logic [DB_W-1:0] cnt_d;

  // Synchronizer, debounced level, its delayed copy and the stability counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
    end
  end

  // Count consecutive samples that disagree with the debounced level; any
  // agreeing sample restarts the count, the DB_CYCLES-th disagreement flips it.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      db_d  = ~db_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Only a coin arriving (rising level) is an event; leaving the sensor is not.
  assign det = db_q & ~db_prev_q;

endmodule

// File: rtl/coin_acceptor.sv
// Vending front-end: two debounced slots feeding an arbitration FSM that
// delivers single-cycle coin pulses, rejects ambiguous inserts and holds one
// coin while the vend FSM is not ready.
//
// Handshake: a coin is offered to the vend FSM on any cycle where the FSM has
// a coin to deliver (fresh detect in IDLE, or the held coin in HOLD). If
// accept_en is high on that cycle the coin is taken and the matching coin_x
// pulse appears on the next cycle; otherwise the coin is held (busy=1).
// accept_en has no effect on cycles where nothing is offered.
module coin_acceptor
  import vend_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int DB_W      = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_5,
  input  logic raw_10,
  input  logic accept_en,
  output logic coin_5,
  output logic coin_10,
  output logic reject,
  output logic busy,
  output logic dbg_state
);

  logic   det_5;
  logic   det_10;
  logic   det_both;
  logic   det_any;
  logic   det_kind;

  state_t state_q;
  state_t state_d;
  logic   kind_q;
  logic   kind_d;
  logic   coin_5_q;
  logic   coin_5_d;
  logic   coin_10_q;
  logic   coin_10_d;
  logic   reject_q;
  logic   reject_d;
  logic   rej_pend_q;
  logic   rej_pend_d;

  coin_debounce #(
    .DB_CYCLES(DB_CYCLES),
    .DB_W     (DB_W)
  ) u_db_5 (
    .clk  (clk),
    .reset(reset),
    .raw  (raw_5),
    .det  (det_5)
  );

  coin_debounce #(
    .DB_CYCLES(DB_CYCLES),
    .DB_W     (DB_W)
  ) u_db_10 (
    .clk  (clk),
    .reset(reset),
    .raw  (raw_10),
    .det  (det_10)
  );

  assign det_both = det_5 & det_10;
  assign det_any  = det_5 | det_10;
  assign det_kind = det_10 ? KIND_10 : KIND_5;

  // State, hold register and registered output pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      kind_q     <= KIND_5;
      coin_5_q   <= 1'b0;
      coin_10_q  <= 1'b0;
      reject_q   <= 1'b0;
      rej_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      coin_5_q   <= coin_5_d;
      coin_10_q  <= coin_10_d;
      reject_q   <= reject_d;
      rej_pend_q <= rej_pend_d;
    end
  end

  // Arbitration: decide which pulse fires next cycle and whether a coin is held.
  // A double detect while the held coin is being emitted defers its reject by
  // one cycle so coin and reject never share a cycle.
  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    coin_5_d   = 1'b0;
    coin_10_d  = 1'b0;
    reject_d   = rej_pend_q;
    rej_pend_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (det_both) begin
          reject_d = 1'b1;
        end else if (det_any) begin
          if (accept_en) begin
            coin_5_d  = (det_kind == KIND_5);
            coin_10_d = (det_kind == KIND_10);
          end else begin
            state_d = HOLD;
            kind_d  = det_kind;
          end
        end
      end
      HOLD: begin
        if (!accept_en) begin
          if (det_any) begin
            reject_d = 1'b1;
          end
        end else begin
          coin_5_d  = (kind_q == KIND_5);
          coin_10_d = (kind_q == KIND_10);
          if (det_both) begin
            rej_pend_d = 1'b1;
            state_d    = IDLE;
          end else if (det_any) begin
            kind_d = det_kind;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign coin_5    = coin_5_q;
  assign coin_10   = coin_10_q;
  assign reject    = reject_q;
  assign busy      = (state_q == HOLD);
  assign dbg_state = state_q;

endmodule
